// File: rtl/mig_seq_evaluator.sv
// mig_seq_evaluator
// Run-time programmable majority-inverter-graph evaluator. The gate table is
// loaded through the cfg_* port while idle. Gates are then evaluated one per
// clock, either for a single input vector or swept over every input pattern
// to build a complete truth table.
module mig_seq_evaluator #(
  parameter int NUM_INPUTS = 4,
  parameter int MAX_GATES  = 8,
  parameter int SEL_W      = $clog2(1 + NUM_INPUTS + MAX_GATES)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_we,
  input  logic [$clog2(MAX_GATES)-1:0]       cfg_addr,
  input  logic [3*SEL_W+2:0]                 cfg_data,
  input  logic [$clog2(MAX_GATES+1)-1:0]     cfg_num_gates,
  input  logic [SEL_W-1:0]                   cfg_out_sel,
  input  logic                               cfg_out_inv,
  output logic                               cfg_ready,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_INPUTS-1:0]              in_x,
  input  logic                               sweep_req,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_y,
  output logic [(1<<NUM_INPUTS)-1:0]         out_tt,
  output logic                               out_is_sweep
);

  localparam int ADDR_W     = $clog2(MAX_GATES);
  localparam int NG_W       = $clog2(MAX_GATES + 1);
  localparam int CFG_W      = 3 * SEL_W + 3;
  localparam int NUM_PAT    = 1 << NUM_INPUTS;
  localparam int FIRST_GATE = NUM_INPUTS + 1;
  localparam logic [NUM_INPUTS-1:0] PAT_LAST = {NUM_INPUTS{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_NEXT, S_DONE} state_t;

  state_t state_q, state_d;

  // Gate table. It is small, so it is read combinationally to keep the
  // one-gate-per-clock rate. It is deliberately not cleared by reset.
  logic [CFG_W-1:0] table_q [MAX_GATES];

  // Captured operation parameters and evaluation state
  logic [NUM_INPUTS-1:0] x_q, x_d;
  logic [NUM_INPUTS-1:0] pat_q, pat_d;
  logic [NG_W-1:0]       k_q, k_d;
  logic [NG_W-1:0]       num_gates_q, num_gates_d;
  logic [SEL_W-1:0]      out_sel_q, out_sel_d;
  logic                  out_inv_q, out_inv_d;
  logic                  sweep_q, sweep_d;
  logic [MAX_GATES-1:0]  gate_val_q, gate_val_d;

  // Result registers
  logic                  out_y_q, out_y_d;
  logic [NUM_PAT-1:0]    out_tt_q, out_tt_d;
  logic                  out_is_sweep_q, out_is_sweep_d;

  // Gate evaluation datapath
  logic [NG_W-1:0]       eval_k;
  logic [NUM_INPUTS-1:0] eval_x;
  logic [NUM_INPUTS-1:0] cur_x;
  logic [CFG_W-1:0]      entry;
  logic [SEL_W-1:0]      sel_a, sel_b, sel_c;
  logic                  val_a, val_b, val_c;
  logic                  gate_new;
  logic                  result;
  logic [NG_W-1:0]       num_gates_in;
  logic                  accept;

  // Value of a node as seen by a consumer that may only look at the first
  // 'visible' gates. Constant node, forward/self references and selects
  // past the table all fall through to 0.
  function automatic logic node_value(
    input logic [SEL_W-1:0]      sel,
    input logic [NUM_INPUTS-1:0] x,
    input logic [MAX_GATES-1:0]  gv,
    input int                    visible
  );
    logic v;
    v = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (int'(sel) == i + 1) v = x[i];
    end
    for (int g = 0; g < MAX_GATES; g++) begin
      if (int'(sel) == FIRST_GATE + g && g < visible) v = gv[g];
    end
    return v;
  endfunction

  assign accept       = sweep_req || in_valid;
  assign num_gates_in = (cfg_num_gates > NG_W'(MAX_GATES)) ? NG_W'(MAX_GATES)
                                                          : cfg_num_gates;
  assign cur_x        = sweep_q ? pat_q : x_q;

  // Evaluate the current gate. In NEXT of a sweep the evaluator is lent to
  // gate 0 of the following pattern: gate 0 can only see the constant and
  // the primary inputs, so it needs nothing from the pattern being finished.
  always_comb begin
    eval_k   = (state_q == S_NEXT) ? '0 : k_q;
    eval_x   = (state_q == S_NEXT) ? pat_q + NUM_INPUTS'(1) : cur_x;
    entry    = table_q[eval_k[ADDR_W-1:0]];
    sel_a    = entry[CFG_W-1 -: SEL_W];
    sel_b    = entry[CFG_W-1-SEL_W -: SEL_W];
    sel_c    = entry[SEL_W+2 -: SEL_W];
    val_a    = node_value(sel_a, eval_x, gate_val_q, int'(eval_k)) ^ entry[2];
    val_b    = node_value(sel_b, eval_x, gate_val_q, int'(eval_k)) ^ entry[1];
    val_c    = node_value(sel_c, eval_x, gate_val_q, int'(eval_k)) ^ entry[0];
    gate_new = (val_a & val_b) | (val_a & val_c) | (val_b & val_c);
    result   = node_value(out_sel_q, cur_x, gate_val_q, MAX_GATES) ^ out_inv_q;
  end

  // Gate-table writes, accepted only while idle
  always_ff @(posedge clk) begin
    if (cfg_we && state_q == S_IDLE) begin
      table_q[cfg_addr] <= cfg_data;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_EVAL;
      S_EVAL: if (k_q == num_gates_q) state_d = S_NEXT;
      S_NEXT: begin
        if (!sweep_q || pat_q == PAT_LAST) begin
          state_d = S_DONE;
        end else if (num_gates_q == '0) begin
          // No gates: the next pattern's result is ready immediately
          state_d = S_NEXT;
        end else begin
          state_d = S_EVAL;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    cfg_ready = (state_q == S_IDLE);
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Datapath next-state: capture, gate evaluation, result collection
  always_comb begin
    x_d            = x_q;
    pat_d          = pat_q;
    k_d            = k_q;
    num_gates_d    = num_gates_q;
    out_sel_d      = out_sel_q;
    out_inv_d      = out_inv_q;
    sweep_d        = sweep_q;
    gate_val_d     = gate_val_q;
    out_y_d        = out_y_q;
    out_tt_d       = out_tt_q;
    out_is_sweep_d = out_is_sweep_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d         = in_x;
          pat_d       = '0;
          k_d         = '0;
          num_gates_d = num_gates_in;
          out_sel_d   = cfg_out_sel;
          out_inv_d   = cfg_out_inv;
          sweep_d     = sweep_req;
          gate_val_d  = '0;
        end
      end
      S_EVAL: begin
        if (k_q != num_gates_q) begin
          gate_val_d[k_q[ADDR_W-1:0]] = gate_new;
          k_d = k_q + NG_W'(1);
        end
      end
      S_NEXT: begin
        if (!sweep_q) begin
          out_y_d        = result;
          out_is_sweep_d = 1'b0;
        end else begin
          out_tt_d[pat_q] = result;
          if (pat_q == PAT_LAST) begin
            out_is_sweep_d = 1'b1;
          end else begin
            pat_d      = pat_q + NUM_INPUTS'(1);
            gate_val_d = '0;
            k_d        = '0;
            if (num_gates_q != '0) begin
              gate_val_d[0] = gate_new;
              k_d           = NG_W'(1);
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q            <= '0;
      pat_q          <= '0;
      k_q            <= '0;
      num_gates_q    <= '0;
      out_sel_q      <= '0;
      out_inv_q      <= 1'b0;
      sweep_q        <= 1'b0;
      gate_val_q     <= '0;
      out_y_q        <= 1'b0;
      out_tt_q       <= '0;
      out_is_sweep_q <= 1'b0;
    end else begin
      x_q            <= x_d;
      pat_q          <= pat_d;
      k_q            <= k_d;
      num_gates_q    <= num_gates_d;
      out_sel_q      <= out_sel_d;
      out_inv_q      <= out_inv_d;
      sweep_q        <= sweep_d;
      gate_val_q     <= gate_val_d;
      out_y_q        <= out_y_d;
      out_tt_q       <= out_tt_d;
      out_is_sweep_q <= out_is_sweep_d;
    end
  end

  assign out_y        = out_y_q;
  assign out_tt       = out_tt_q;
  assign out_is_sweep = out_is_sweep_q;

endmodule
